// File: rtl/fdct_pkg.sv
// Shared constants and rounding helper for the 4x4 forward DCT row/column passes.
// Both passes use the same 64/83/36 butterfly.
package fdct_pkg;

  localparam logic signed [7:0] C64 = 8'sd64;
  localparam logic signed [7:0] C83 = 8'sd83;
  localparam logic signed [7:0] C36 = 8'sd36;

  // Round half up, arithmetic shift, then clamp to a signed ow-bit range.
  function automatic logic signed [63:0] round_sat(input logic signed [63:0] value,
                                                   input int shift,
                                                   input int ow);
    logic signed [63:0] res;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    res   = (value + (64'sd1 <<< (shift - 1))) >>> shift;
    max_v = (64'sd1 <<< (ow - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (ow - 1));
    if (res > max_v) return max_v;
    if (res < min_v) return min_v;
    return res;
  endfunction

endpackage

// File: rtl/dct4_butterfly.sv
// 4-point DCT-II butterfly: stage 1 registers full-precision products, stage 2 rounds
// and saturates. With OUT_REG=0 the caller supplies the stage-2 register.
module dct4_butterfly
  import fdct_pkg::*;
#(
  parameter int IW_IN   = 25,
  parameter int SHIFT   = 1,
  parameter int OW      = 32,
  parameter int TW      = 1,
  parameter bit OUT_REG = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [TW-1:0]           in_tag,
  input  logic signed [IW_IN-1:0] in_a [4],
  output logic                    out_valid,
  output logic [TW-1:0]           out_tag,
  output logic signed [OW-1:0]    out_y [4]
);

  localparam int PW = IW_IN + 9;

  logic signed [PW-1:0] e0, e1, o0, o1;
  logic signed [PW-1:0] b_d [4];
  logic signed [PW-1:0] b_q [4];
  logic                 s1_valid_q;
  logic [TW-1:0]        s1_tag_q;
  logic signed [OW-1:0] y_rnd [4];

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    e0     = PW'(in_a[0]) + PW'(in_a[3]);
    e1     = PW'(in_a[1]) + PW'(in_a[2]);
    o0     = PW'(in_a[0]) - PW'(in_a[3]);
    o1     = PW'(in_a[1]) - PW'(in_a[2]);
    b_d[0] = PW'(C64) * (e0 + e1);
    b_d[2] = PW'(C64) * (e0 - e1);
    b_d[1] = PW'(C83) * o0 + PW'(C36) * o1;
    b_d[3] = PW'(C36) * o0 - PW'(C83) * o1;
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_tag_q   <= '0;
      for (int k = 0; k < 4; k++) b_q[k] <= '0;
    end else begin
      s1_valid_q <= in_valid;
      s1_tag_q   <= in_tag;
      for (int k = 0; k < 4; k++) b_q[k] <= b_d[k];
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) y_rnd[k] = OW'(round_sat(64'(b_q[k]), SHIFT, OW));
  end

  if (OUT_REG) begin : g_out_reg
    logic                 valid_q;
    logic [TW-1:0]        tag_q, tag_d;
    logic signed [OW-1:0] y_q [4];
    logic signed [OW-1:0] y_d [4];

    // Outputs hold their last value while no result is presented.
    always_comb begin
      tag_d = tag_q;
      y_d   = y_q;
      if (s1_valid_q) begin
        tag_d = s1_tag_q;
        y_d   = y_rnd;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        valid_q <= 1'b0;
        tag_q   <= '0;
        for (int k = 0; k < 4; k++) y_q[k] <= '0;
      end else begin
        valid_q <= s1_valid_q;
        tag_q   <= tag_d;
        for (int k = 0; k < 4; k++) y_q[k] <= y_d[k];
      end
    end

    assign out_valid = valid_q;
    assign out_tag   = tag_q;
    assign out_y     = y_q;
  end else begin : g_out_comb
    assign out_valid = s1_valid_q;
    assign out_tag   = s1_tag_q;
    assign out_y     = y_rnd;
  end

endmodule

// File: rtl/fdct4x4_2d.sv
// Forward 4x4 2D integer DCT: row pass into a ping-pong transpose buffer, then a
// column pass emitting one coefficient column per cycle.
module fdct4x4_2d
  import fdct_pkg::*;
#(
  parameter int DW     = 25,
  parameter int IW     = 32,
  parameter int SHIFT1 = 1,
  parameter int SHIFT2 = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic                 in_sof,
  input  logic signed [DW-1:0] in_0,
  input  logic signed [DW-1:0] in_1,
  input  logic signed [DW-1:0] in_2,
  input  logic signed [DW-1:0] in_3,
  output logic                 out_valid,
  output logic                 out_sof,
  output logic signed [DW-1:0] out_0,
  output logic signed [DW-1:0] out_1,
  output logic signed [DW-1:0] out_2,
  output logic signed [DW-1:0] out_3,
  output logic                 err_partial
);

  logic [1:0]           row_cnt_q, row_cnt_d, eff_row;
  logic                 wr_bank_q, wr_bank_d;
  logic signed [DW-1:0] row_a [4];
  logic                 row_v;
  logic [2:0]           row_tag;
  logic signed [IW-1:0] row_t [4];
  logic signed [IW-1:0] tbuf_q [2][4][4];
  logic [1:0]           full_q, full_d;
  logic                 rd_bank_q, rd_bank_d;
  logic [1:0]           rd_u_q, rd_u_d;
  logic                 col_v_in;
  logic signed [IW-1:0] col_a [4];
  logic signed [DW-1:0] col_y [4];

  assign err_partial = in_valid && in_sof && (row_cnt_q != 2'd0);
  assign row_a       = '{in_0, in_1, in_2, in_3};

  // A start-of-block row always lands at row 0, discarding any partial block.
  always_comb begin
    eff_row   = in_sof ? 2'd0 : row_cnt_q;
    row_cnt_d = row_cnt_q;
    wr_bank_d = wr_bank_q;
    if (in_valid) begin
      row_cnt_d = eff_row + 2'd1;
      if (eff_row == 2'd3) wr_bank_d = ~wr_bank_q;
    end
  end

  dct4_butterfly #(
    .IW_IN(DW), .SHIFT(SHIFT1), .OW(IW), .TW(3), .OUT_REG(1'b0)
  ) u_row (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_tag({wr_bank_q, eff_row}), .in_a(row_a),
    .out_valid(row_v), .out_tag(row_tag), .out_y(row_t)
  );

  // NOTE: the transpose buffer is not reset; the bank-full flags gate every read.
  always_ff @(posedge clk) begin
    if (row_v) begin
      for (int k = 0; k < 4; k++) tbuf_q[row_tag[2]][row_tag[1:0]][k] <= row_t[k];
    end
  end

  always_comb begin
    full_d    = full_q;
    rd_bank_d = rd_bank_q;
    rd_u_d    = rd_u_q;
    col_v_in  = full_q[rd_bank_q];
    if (col_v_in) begin
      rd_u_d = rd_u_q + 2'd1;
      if (rd_u_q == 2'd3) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
      end
    end
    if (row_v && row_tag[1:0] == 2'd3) full_d[row_tag[2]] = 1'b1;
    for (int k = 0; k < 4; k++) col_a[k] = tbuf_q[rd_bank_q][k][rd_u_q];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_cnt_q <= 2'd0;
      wr_bank_q <= 1'b0;
      full_q    <= 2'b00;
      rd_bank_q <= 1'b0;
      rd_u_q    <= 2'd0;
    end else begin
      row_cnt_q <= row_cnt_d;
      wr_bank_q <= wr_bank_d;
      full_q    <= full_d;
      rd_bank_q <= rd_bank_d;
      rd_u_q    <= rd_u_d;
    end
  end

  dct4_butterfly #(
    .IW_IN(IW), .SHIFT(SHIFT2), .OW(DW), .TW(1), .OUT_REG(1'b1)
  ) u_col (
    .clk(clk), .reset(reset),
    .in_valid(col_v_in), .in_tag(rd_u_q == 2'd0), .in_a(col_a),
    .out_valid(out_valid), .out_tag(out_sof), .out_y(col_y)
  );

  assign out_0 = col_y[0];
  assign out_1 = col_y[1];
  assign out_2 = col_y[2];
  assign out_3 = col_y[3];

endmodule

// File: tb/tb_fdct4x4_2d.sv
// Scoreboard bench for fdct4x4_2d: directed blocks push hand-computed columns with
// their expected output cycle; monitors pop and compare whenever out_valid is high.
module tb_fdct4x4_2d;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic                in_valid, in_sof;
  logic signed [24:0]  x0, x1, x2, x3;
  logic                out_valid, out_sof, err_partial;
  logic signed [24:0]  y0, y1, y2, y3;

  logic                s_valid, s_sof;
  logic signed [8:0]   sx0, sx1, sx2, sx3;
  logic                s_out_valid, s_out_sof, s_err;
  logic signed [8:0]   sy0, sy1, sy2, sy3;

  fdct4x4_2d dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_sof(in_sof),
    .in_0(x0), .in_1(x1), .in_2(x2), .in_3(x3),
    .out_valid(out_valid), .out_sof(out_sof),
    .out_0(y0), .out_1(y1), .out_2(y2), .out_3(y3), .err_partial(err_partial)
  );

  fdct4x4_2d #(.DW(9), .IW(32), .SHIFT1(1), .SHIFT2(8)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(s_valid), .in_sof(s_sof),
    .in_0(sx0), .in_1(sx1), .in_2(sx2), .in_3(sx3),
    .out_valid(s_out_valid), .out_sof(s_out_sof),
    .out_0(sy0), .out_1(sy1), .out_2(sy2), .out_3(sy3), .err_partial(s_err)
  );

  typedef struct {
    int     edge_n;
    logic   sof;
    longint c0, c1, c2, c3;
  } exp_t;

  exp_t q_main[$];
  exp_t q_sat[$];
  int   edge_cnt = 0;
  int   n_tests  = 0;
  int   n_fail   = 0;

  longint imp_tbl [4][4] = '{'{512, 664, 512, 288}, '{664, 861, 664, 374},
                             '{512, 664, 512, 288}, '{288, 374, 288, 162}};

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_out(input string tag, input exp_t ex, input logic sof,
                             input longint a0, input longint a1, input longint a2, input longint a3);
    check({tag, "_cycle"}, edge_cnt, ex.edge_n);
    check({tag, "_sof"}, sof, ex.sof);
    check({tag, "_y0"}, a0, ex.c0);
    check({tag, "_y1"}, a1, ex.c1);
    check({tag, "_y2"}, a2, ex.c2);
    check({tag, "_y3"}, a3, ex.c3);
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (q_main.size() == 0) check("main_unexpected_valid", out_valid, 0);
      else compare_out("main", q_main.pop_front(), out_sof, y0, y1, y2, y3);
    end
    if (!reset && s_out_valid) begin
      if (q_sat.size() == 0) check("sat_unexpected_valid", s_out_valid, 0);
      else begin
        compare_out("sat", q_sat.pop_front(), s_out_sof, sy0, sy1, sy2, sy3);
        check("sat_err", s_err, 0);
      end
    end
  end

  task automatic drive(input bit sat, input logic v, input logic sof,
                       input int a0, input int a1, input int a2, input int a3, output int e);
    @(negedge clk);
    if (sat) begin
      s_valid = v; s_sof = sof;
      sx0 = 9'(a0); sx1 = 9'(a1); sx2 = 9'(a2); sx3 = 9'(a3);
    end else begin
      in_valid = v; in_sof = sof;
      x0 = 25'(a0); x1 = 25'(a1); x2 = 25'(a2); x3 = 25'(a3);
    end
    e = edge_cnt + 1;
  endtask

  task automatic idle(input int n);
    int d;
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, d);
      s_valid = 1'b0;
      in_valid = 1'b0; in_sof = 1'b0;
    end
  endtask

  task automatic send_uniform(input bit sat, input int v, output int e);
    for (int r = 0; r < 4; r++) drive(sat, 1'b1, r == 0, v, v, v, v, e);
  endtask

  task automatic send_impulse(output int e);
    for (int r = 0; r < 4; r++) drive(1'b0, 1'b1, r == 0, (r == 0) ? 64 : 0, 0, 0, 0, e);
  endtask

  task automatic exp_col(input bit sat, input int edge_n, input logic sof,
                         input longint c0, input longint c1, input longint c2, input longint c3);
    exp_t ex;
    ex.edge_n = edge_n; ex.sof = sof;
    ex.c0 = c0; ex.c1 = c1; ex.c2 = c2; ex.c3 = c3;
    if (sat) q_sat.push_back(ex);
    else q_main.push_back(ex);
  endtask

  // Row 3 captured on edge e: columns appear after edges e+3..e+6.
  task automatic exp_uniform(input bit sat, input int e, input longint dc);
    exp_col(sat, e + 3, 1'b1, dc, 0, 0, 0);
    for (int u = 1; u < 4; u++) exp_col(sat, e + 3 + u, 1'b0, 0, 0, 0, 0);
  endtask

  task automatic exp_impulse(input int e, input int ncols);
    for (int u = 0; u < ncols; u++)
      exp_col(1'b0, e + 3 + u, u == 0, imp_tbl[u][0], imp_tbl[u][1], imp_tbl[u][2], imp_tbl[u][3]);
  endtask

  initial begin
    int e, e1, e2, e3;
    reset = 1'b1;
    in_valid = 1'b0; in_sof = 1'b0; x0 = '0; x1 = '0; x2 = '0; x3 = '0;
    s_valid = 1'b0; s_sof = 1'b0; sx0 = '0; sx1 = '0; sx2 = '0; sx3 = '0;
    #23;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sof", out_sof, 0);
    check("rst_out_0", y0, 0);
    check("rst_err_partial", err_partial, 0);
    @(negedge clk);
    reset = 1'b0;
    idle(2);

    // DC block; an in_sof at row counter 0 must not flag an error
    drive(1'b0, 1'b1, 1'b1, 1, 1, 1, 1, e);
    #1 check("dc_sof_no_err", err_partial, 0);
    for (int r = 1; r < 4; r++) drive(1'b0, 1'b1, 1'b0, 1, 1, 1, 1, e);
    exp_uniform(1'b0, e, 128);
    idle(10);

    send_impulse(e);
    exp_impulse(e, 4);
    idle(10);

    // Three back-to-back blocks: outputs must be contiguous
    send_uniform(1'b0, 1, e1);
    exp_uniform(1'b0, e1, 128);
    send_impulse(e2);
    exp_impulse(e2, 4);
    send_uniform(1'b0, -1, e3);
    exp_uniform(1'b0, e3, -128);
    idle(12);

    send_uniform(1'b1, 255, e);
    exp_uniform(1'b1, e, 255);
    idle(12);

    // Resync: two rows of a stale block, then a fresh impulse block
    drive(1'b0, 1'b1, 1'b1, 5, 5, 5, 5, e);
    drive(1'b0, 1'b1, 1'b0, 5, 5, 5, 5, e);
    drive(1'b0, 1'b1, 1'b1, 64, 0, 0, 0, e);
    #1 check("resync_err_pulse", err_partial, 1);
    drive(1'b0, 1'b1, 1'b0, 0, 0, 0, 0, e);
    #1 check("resync_err_cleared", err_partial, 0);
    drive(1'b0, 1'b1, 1'b0, 0, 0, 0, 0, e);
    drive(1'b0, 1'b1, 1'b0, 0, 0, 0, 0, e);
    exp_impulse(e, 4);
    idle(12);

    // Reset while column u=1 is on the outputs
    send_impulse(e);
    exp_impulse(e, 1);
    idle(1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (edge_cnt >= e + 4) break;
    end
    check("mid_out_valid_before_reset", out_valid, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_0", y0, 0);
    check("mid_rst_out_1", y1, 0);
    check("mid_rst_err", err_partial, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    idle(2);
    send_uniform(1'b0, 1, e);
    exp_uniform(1'b0, e, 128);
    idle(2);

    for (int i = 0; i < 40 && (q_main.size() != 0 || q_sat.size() != 0); i++) @(negedge clk);
    check("main_queue_drained", q_main.size(), 0);
    check("sat_queue_drained", q_sat.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
